// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Quotient reported for a zero divisor; sliced to the operand width by users.
    localparam logic [63:0] DIV0_QUOT = '1;

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Two's-complement conditional negate; abs() when neg is the value's own sign bit.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mthi,
    input  logic              mtlo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    // Handshake: start is taken only while busy is low; busy stays high from
    // the accepting edge until the commit edge, and done pulses for the one
    // cycle in which the new hi/lo first become visible. No queuing.

    state_e              state;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   rs_q;
    logic                neg_q;
    logic                rem_neg_q;
    logic                div0_q;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    counter;

    logic                in_signed;
    logic [DATA_W-1:0]   rs_abs;
    logic [DATA_W-1:0]   rt_abs;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;

    assign in_signed = op_is_signed(op_e'(op));
    assign busy      = (state != ST_IDLE);

    mdu_signfix #(.W(DATA_W)) u_abs_rs (
        .value  (rs_data),
        .neg    (in_signed & rs_data[DATA_W-1]),
        .result (rs_abs)
    );

    mdu_signfix #(.W(DATA_W)) u_abs_rt (
        .value  (rt_data),
        .neg    (in_signed & rt_data[DATA_W-1]),
        .result (rt_abs)
    );

    mdu_signfix #(.W(2*DATA_W)) u_fix_prod (
        .value  (acc),
        .neg    (neg_q),
        .result (prod_fix)
    );

    mdu_signfix #(.W(DATA_W)) u_fix_quot (
        .value  (acc[DATA_W-1:0]),
        .neg    (neg_q),
        .result (quot_fix)
    );

    mdu_signfix #(.W(DATA_W)) u_fix_rem (
        .value  (acc[2*DATA_W-1:DATA_W]),
        .neg    (rem_neg_q),
        .result (rem_fix)
    );

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? a_q : {DATA_W{1'b0}})};
        div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        acc_next  = acc;
        if (op_q == OP_DIV || op_q == OP_DIVU) begin
            if (!div_diff[DATA_W])
                acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
                acc_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            rs_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            acc       <= '0;
            counter   <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op_e'(op);
                        a_q       <= rs_abs;
                        b_q       <= rt_abs;
                        rs_q      <= rs_data;
                        neg_q     <= in_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                        rem_neg_q <= in_signed & rs_data[DATA_W-1];
                        div0_q    <= (rt_data == '0);
                        acc       <= {{DATA_W{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                        counter   <= '0;
                        state     <= ST_CALC;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                ST_CALC: begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                    if (counter == LAST_STEP)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    if (op_q == OP_DIV || op_q == OP_DIVU) begin
                        if (div0_q) begin
                            hi <= rs_q;
                            lo <= DIV0_QUOT[DATA_W-1:0];
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_move(input logic [31:0] v, input logic set_hi, input logic set_lo);
        @(negedge clk);
        rs_data = v;
        mthi    = set_hi;
        mtlo    = set_lo;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (set_hi) m_hi = v;
        if (set_lo) m_lo = v;
        check("move_hi", hi, m_hi);
        check("move_lo", lo, m_lo);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit with_move, input bit disturb);
        int n;
        int busy_gap;
        @(negedge clk);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        mthi    = with_move;
        mtlo    = with_move;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        op      = 2'b00;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h0BAD_F00D;
        check({name, "_busy_e0"}, busy, 1);
        check({name, "_hold_hi"}, hi, m_hi);
        check({name, "_hold_lo"}, lo, m_lo);
        n = 0;
        busy_gap = 0;
        while (n < 40 && !done) begin
            if (disturb && n == 5) begin
                op      = 2'b01;
                rs_data = 32'd3;
                rt_data = 32'd3;
                start   = 1'b1;
                mthi    = 1'b1;
                mtlo    = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 6) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
                check({name, "_busy_mthi"}, hi, m_hi);
                check({name, "_busy_mtlo"}, lo, m_lo);
            end
            if (!done && !busy) busy_gap++;
        end
        check({name, "_latency"}, n, 33);
        check({name, "_busy_gap"}, busy_gap, 0);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n_done;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'h0;
        rt_data = 32'h0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        m_hi    = 32'h0;
        m_lo    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_move(32'h0000_1234, 1'b0, 1'b1);
        do_move(32'hA5A5_5A5A, 1'b1, 1'b1);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu_dist", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b1);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 1'b0);
        run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_pos",  2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0,         32'd20,        1'b0, 1'b0);

        // Abort mid-operation: asynchronous reset after 10 CALC edges.
        @(negedge clk);
        op      = 2'b01;
        rs_data = 32'h1234_5678;
        rt_data = 32'h9ABC_DEF0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_idle", busy, 0);
        check("abort_lo_kept", lo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
